// File: rtl/alu_op_sequencer.sv
// Request/response sequencer for the lab's 4-bit combinational ALU, with a result accumulator.
// Optional self-check of captured ALU results is enabled by defining ALU_OP_SEQUENCER_CHECK_EN.
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    input  logic       req_use_acc,
    output logic [3:0] alu_A,
    output logic [3:0] alu_B,
    output logic [2:0] alu_s,
    input  logic [3:0] alu_res,
    input  logic       alu_CF,
    input  logic       alu_OF,
    input  logic       alu_ZF,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_res,
    output logic       rsp_cf,
    output logic       rsp_of,
    output logic       rsp_zf,
    output logic [2:0] rsp_op,
    output logic [3:0] acc
`ifdef ALU_OP_SEQUENCER_CHECK_EN
    ,
    output logic       chk_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 32'd1);

    state_t     state_r;
    logic [3:0] cnt_r;

`ifdef ALU_OP_SEQUENCER_CHECK_EN
    // Expected {CF, OF, ZF, res} of the lab ALU for one operation.
    function automatic logic [6:0] alu_model(input logic [2:0] op,
                                             input logic [3:0] a,
                                             input logic [3:0] b);
        logic [4:0] sum;
        logic [3:0] bx;
        logic [3:0] res;
        logic       cf;
        logic       of;
        logic       zf;
        sum = 5'd0;
        bx  = b;
        res = 4'd0;
        cf  = 1'b0;
        of  = 1'b0;
        case (op)
            3'd0: begin
                sum = {1'b0, a} + {1'b0, bx};
                res = sum[3:0];
                cf  = sum[4];
                of  = (a[3] == bx[3]) && (res[3] != a[3]);
            end
            3'd1: begin
                bx  = ~b;
                sum = {1'b0, a} + {1'b0, bx} + 5'd1;
                res = sum[3:0];
                cf  = sum[4];
                of  = (a[3] == bx[3]) && (res[3] != a[3]);
            end
            3'd2:    res = ~a;
            3'd3:    res = a & b;
            3'd4:    res = a | b;
            3'd5:    res = a ^ b;
            3'd6:    res = {3'b000, ($signed(a) > $signed(b))};
            3'd7:    res = {3'b000, (a == b)};
            default: res = 4'd0;
        endcase
        zf = (op <= 3'd5) ? (res == 4'd0) : 1'b0;
        return {cf, of, zf, res};
    endfunction
`endif

    // Control FSM with all handshake, ALU-drive and response outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            alu_A     <= 4'd0;
            alu_B     <= 4'd0;
            alu_s     <= 3'd0;
            rsp_res   <= 4'd0;
            rsp_cf    <= 1'b0;
            rsp_of    <= 1'b0;
            rsp_zf    <= 1'b0;
            rsp_op    <= 3'd0;
            acc       <= 4'd0;
`ifdef ALU_OP_SEQUENCER_CHECK_EN
            chk_err   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        alu_A     <= req_use_acc ? acc : req_a;
                        alu_B     <= req_b;
                        alu_s     <= req_op;
                        cnt_r     <= SETTLE_LOAD;
                        req_ready <= 1'b0;
                        state_r   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Capture happens on the SETTLE_CYCLES-th edge after acceptance.
                    if (cnt_r == 4'd0) begin
                        rsp_res   <= alu_res;
                        rsp_cf    <= alu_CF;
                        rsp_of    <= alu_OF;
                        rsp_zf    <= alu_ZF;
                        rsp_op    <= alu_s;
                        acc       <= alu_res;
                        rsp_valid <= 1'b1;
                        state_r   <= ST_RESP;
`ifdef ALU_OP_SEQUENCER_CHECK_EN
                        if (alu_model(alu_s, alu_A, alu_B) != {alu_CF, alu_OF, alu_ZF, alu_res}) begin
                            chk_err <= 1'b1;
                        end
`endif
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
